// File: rtl/mm2s_unpack.sv
// Unpacks FWFT FIFO words of C_PACK flagged pixels into an AXI4-Stream video stream
// of C_PPC pixels per beat, generating tuser/tlast from line/row counters.
module mm2s_unpack #(
  parameter int unsigned C_PIXEL_WIDTH = 8,
  parameter int unsigned C_PACK        = 4,
  parameter int unsigned C_PPC         = 1,
  parameter int unsigned C_IMG_WBITS   = 12,
  parameter int unsigned C_IMG_HBITS   = 12
) (
  input  logic                                  f2s_aclk,
  input  logic                                  f2s_reset,
  input  logic [C_IMG_WBITS-1:0]                img_width,
  input  logic [C_IMG_HBITS-1:0]                img_height,
  input  logic                                  fifo_empty,
  input  logic [C_PACK*(C_PIXEL_WIDTH+2)-1:0]   fifo_rd_data,
  output logic                                  fifo_rd_en,
  output logic                                  m_axis_tvalid,
  output logic [C_PPC*C_PIXEL_WIDTH-1:0]        m_axis_tdata,
  output logic                                  m_axis_tuser,
  output logic                                  m_axis_tlast,
  input  logic                                  m_axis_tready,
  output logic                                  frame_done,
  output logic                                  err_sof,
  output logic                                  err_eol,
  input  logic                                  err_clr
);

  localparam int unsigned LaneW    = C_PIXEL_WIDTH + 2;
  localparam int unsigned NumBeats = C_PACK / C_PPC;
  localparam int unsigned BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned LaneIdxW = (C_PACK > 1) ? $clog2(C_PACK) : 1;

  logic [BeatW-1:0]       beat_q;
  logic [C_IMG_WBITS-1:0] col_q, w_q;
  logic [C_IMG_HBITS-1:0] row_q, h_q;
  logic                   eof_q;

  logic [LaneW-1:0]               lanes [C_PACK];
  logic [C_PPC*C_PIXEL_WIDTH-1:0] pix;
  logic [LaneIdxW-1:0]            lane_idx;
  logic                           beat_sof, beat_eol;
  logic                           at_start, resync, new_frame, geo_ok, load;
  logic                           last_col, last_row, last_beat;
  logic [C_IMG_WBITS-1:0]         eff_w, eff_col, line_beats;
  logic [C_IMG_HBITS-1:0]         eff_h, eff_row;
  logic                           set_sof, set_eol;

  always_comb begin
    for (int k = 0; k < C_PACK; k++) begin
      lanes[k] = fifo_rd_data[k*LaneW +: LaneW];
    end
  end

  always_comb begin
    pix      = '0;
    beat_eol = 1'b0;
    lane_idx = '0;
    for (int i = 0; i < C_PPC; i++) begin
      lane_idx = LaneIdxW'(32'(beat_q) * C_PPC + i);
      pix[i*C_PIXEL_WIDTH +: C_PIXEL_WIDTH] = lanes[lane_idx][C_PIXEL_WIDTH-1:0];
      beat_eol = beat_eol | lanes[lane_idx][C_PIXEL_WIDTH+1];
    end
    beat_sof = lanes[LaneIdxW'(32'(beat_q) * C_PPC)][C_PIXEL_WIDTH];
  end

  // A stray sof restarts the frame at (0,0); geometry is re-latched from the ports then too.
  always_comb begin
    at_start   = (col_q == '0) && (row_q == '0);
    resync     = beat_sof && !at_start;
    new_frame  = at_start || resync;
    geo_ok     = (img_width >= C_IMG_WBITS'(C_PPC)) && (img_height != '0);
    eff_w      = new_frame ? img_width : w_q;
    eff_h      = new_frame ? img_height : h_q;
    eff_col    = resync ? '0 : col_q;
    eff_row    = resync ? '0 : row_q;
    line_beats = eff_w / C_IMG_WBITS'(C_PPC);
    last_col   = eff_col == (line_beats - C_IMG_WBITS'(1));
    last_row   = eff_row == (eff_h - C_IMG_HBITS'(1));
    last_beat  = beat_q == BeatW'(NumBeats - 1);
    load       = !f2s_reset && !fifo_empty && (!m_axis_tvalid || m_axis_tready) &&
                 (!new_frame || geo_ok);
    fifo_rd_en = load && (last_beat || last_col);
    set_sof    = load && (resync || (at_start && !beat_sof));
    set_eol    = load && (beat_eol != last_col);
  end

  always_ff @(posedge f2s_aclk) begin
    if (f2s_reset) begin
      beat_q        <= '0;
      col_q         <= '0;
      row_q         <= '0;
      w_q           <= '0;
      h_q           <= '0;
      eof_q         <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_done    <= 1'b0;
      err_sof       <= 1'b0;
      err_eol       <= 1'b0;
    end else begin
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= pix;
        m_axis_tuser  <= (eff_col == '0) && (eff_row == '0);
        m_axis_tlast  <= last_col;
        eof_q         <= last_col && last_row;
        beat_q        <= fifo_rd_en ? '0 : beat_q + BeatW'(1);
        if (last_col) begin
          col_q <= '0;
          row_q <= last_row ? '0 : eff_row + C_IMG_HBITS'(1);
        end else begin
          col_q <= eff_col + C_IMG_WBITS'(1);
          row_q <= eff_row;
        end
        if (new_frame) begin
          w_q <= img_width;
          h_q <= img_height;
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      frame_done <= m_axis_tvalid && m_axis_tready && eof_q;
      err_sof    <= set_sof || (err_sof && !err_clr);
      err_eol    <= set_eol || (err_eol && !err_clr);
    end
  end

endmodule

// File: tb/tb_mm2s_unpack.sv
// Bench for mm2s_unpack: FWFT FIFO model, expected-beat scoreboard, per-scenario tasks.
module tb_mm2s_unpack;
  localparam int P = 8, PACK = 4, PPC = 1, WB = 12, HB = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, fifo_empty, fifo_rd_en, tvalid, tuser, tlast, tready;
  logic frame_done, err_sof, err_eol, err_clr;
  logic [WB-1:0] img_width;
  logic [HB-1:0] img_height;
  logic [PACK*(P+2)-1:0] fifo_rd_data;
  logic [PPC*P-1:0] tdata;

  mm2s_unpack #(.C_PIXEL_WIDTH(P), .C_PACK(PACK), .C_PPC(PPC),
                .C_IMG_WBITS(WB), .C_IMG_HBITS(HB)) dut (
    .f2s_aclk(clk), .f2s_reset(rst), .img_width(img_width), .img_height(img_height),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .m_axis_tuser(tuser),
    .m_axis_tlast(tlast), .m_axis_tready(tready), .frame_done(frame_done),
    .err_sof(err_sof), .err_eol(err_eol), .err_clr(err_clr));

  typedef struct packed {logic [7:0] data; logic user; logic last; logic eof;} beat_t;

  beat_t exp_q[$];
  logic [39:0] fq[$];
  int checks = 0, errors = 0, pops = 0, beats_seen = 0;
  bit mon_en = 1'b0, fd_exp = 1'b0;

  task automatic fifo_refresh();
    fifo_empty   = (fq.size() == 0);
    fifo_rd_data = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push_word(input logic [7:0] base, input logic [3:0] sof, input logic [3:0] eol);
    logic [39:0] w;
    for (int k = 0; k < 4; k++) begin
      w[k*10 +: 8] = base + 8'(k);
      w[k*10 + 8]  = sof[k];
      w[k*10 + 9]  = eol[k];
    end
    fq.push_back(w);
    fifo_refresh();
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic u, input logic l, input logic e);
    beat_t b;
    b.data = d; b.user = u; b.last = l; b.eof = e;
    exp_q.push_back(b);
  endtask

  // FWFT FIFO: a pop requested before the edge takes effect just after it.
  always @(posedge clk) begin
    bit do_pop;
    do_pop = (fifo_rd_en === 1'b1);
    #1;
    if (do_pop) begin
      pops++;
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL fifo_underflow: rd_en=1 with fifo empty, required rd_en=0");
      end else void'(fq.pop_front());
    end
    fifo_refresh();
  end

  always @(negedge clk) begin
    beat_t e;
    if (mon_en && !rst) begin
      checks++;
      if (frame_done !== fd_exp) begin
        errors++;
        $display("FAIL frame_done: got %b required %b", frame_done, fd_exp);
      end
      fd_exp = 1'b0;
      if (tvalid === 1'b1 && tready === 1'b1) begin
        beats_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got data=%h user=%b last=%b, required no beat",
                   tdata, tuser, tlast);
        end else begin
          e = exp_q.pop_front();
          if ({tdata, tuser, tlast} !== {e.data, e.user, e.last}) begin
            errors++;
            $display("FAIL beat: got data=%h user=%b last=%b required data=%h user=%b last=%b",
                     tdata, tuser, tlast, e.data, e.user, e.last);
          end
          fd_exp = e.eof;
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic clear_errors();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; tready = 1'b0; err_clr = 1'b0; img_width = 12'd8; img_height = 12'd2;
    fifo_refresh();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tvalid, tuser, tlast, fifo_rd_en, frame_done, err_sof, err_eol} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got v/u/l/rd/fd/es/ee=%b required 0000000",
               {tvalid, tuser, tlast, fifo_rd_en, frame_done, err_sof, err_eol});
    end
    checks++;
    if (tdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_tdata: got %h required 00", tdata);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int p0 = pops;
    logic [7:0] bases [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    img_width = 12'd8; img_height = 12'd2; tready = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 8; c++)
        expect_beat(bases[r*2 + c/4] + 8'(c%4), (r == 0 && c == 0), (c == 7), (r == 1 && c == 7));
    push_word(8'h10, 4'b0001, 4'b0000);
    push_word(8'h20, 4'b0000, 4'b1000);
    push_word(8'h30, 4'b0000, 4'b0000);
    push_word(8'h40, 4'b0000, 4'b1000);
    checks++;
    if (tvalid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got tvalid=%b required 0", tvalid);
    end
    @(negedge clk);
    checks++;
    if (tvalid !== 1'b1) begin
      errors++;
      $display("FAIL latency: got tvalid=%b required 1", tvalid);
    end
    wait_drain("basic");
    checks++;
    if (pops - p0 != 4) begin
      errors++;
      $display("FAIL basic_pops: got %0d required 4", pops - p0);
    end
    checks++;
    if ({err_sof, err_eol} !== 2'b00) begin
      errors++;
      $display("FAIL basic_err: got sof/eol=%b required 00", {err_sof, err_eol});
    end
  endtask

  task automatic test_partial_word();
    int p0 = pops;
    img_width = 12'd6; img_height = 12'd1; tready = 1'b1;
    for (int c = 0; c < 6; c++)
      expect_beat(((c < 4) ? 8'h50 : 8'h5C) + 8'(c), (c == 0), (c == 5), (c == 5));
    push_word(8'h50, 4'b0001, 4'b0000);
    push_word(8'h60, 4'b0000, 4'b0010);
    wait_drain("partial");
    checks++;
    if (pops - p0 != 2 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL partial_pops: got %0d pops empty=%b required 2 pops empty=1",
               pops - p0, fifo_empty);
    end
    checks++;
    if (err_eol !== 1'b0) begin
      errors++;
      $display("FAIL partial_err_eol: got %b required 0", err_eol);
    end
  endtask

  task automatic test_stall();
    int p0 = pops, n = 0;
    img_width = 12'd8; img_height = 12'd1; tready = 1'b0;
    for (int c = 0; c < 8; c++)
      expect_beat(((c < 4) ? 8'h70 : 8'h7C) + 8'(c), (c == 0), (c == 7), (c == 7));
    push_word(8'h70, 4'b0001, 4'b0000);
    push_word(8'h80, 4'b0000, 4'b1000);
    do begin
      @(posedge clk); #1;
      n++;
    end while (tvalid !== 1'b1 && n < 10);
    tready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (tdata !== 8'h72 || tvalid !== 1'b1 || fifo_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got data=%h valid=%b rd_en=%b required data=72 valid=1 rd_en=0",
                 tdata, tvalid, fifo_rd_en);
      end
    end
    @(posedge clk); #1 tready = 1'b1;
    wait_drain("stall");
    checks++;
    if (pops - p0 != 2) begin
      errors++;
      $display("FAIL stall_pops: got %0d required 2", pops - p0);
    end
  endtask

  task automatic test_sof_resync();
    int p0 = pops;
    img_width = 12'd8; img_height = 12'd1; tready = 1'b1;
    expect_beat(8'h90, 1, 0, 0); expect_beat(8'h91, 0, 0, 0); expect_beat(8'h92, 0, 0, 0);
    expect_beat(8'h93, 1, 0, 0);
    for (int c = 0; c < 4; c++) expect_beat(8'hA0 + 8'(c), 0, 0, 0);
    expect_beat(8'hB0, 0, 0, 0); expect_beat(8'hB1, 0, 0, 0); expect_beat(8'hB2, 0, 1, 1);
    push_word(8'h90, 4'b1001, 4'b0000);
    push_word(8'hA0, 4'b0000, 4'b0000);
    push_word(8'hB0, 4'b0000, 4'b0100);
    wait_drain("sof");
    checks++;
    if ({err_sof, err_eol} !== 2'b10 || pops - p0 != 3) begin
      errors++;
      $display("FAIL sof_err: got sof/eol=%b pops=%0d required 10 pops=3",
               {err_sof, err_eol}, pops - p0);
    end
    clear_errors();
    checks++;
    if (err_sof !== 1'b0) begin
      errors++;
      $display("FAIL sof_clear: got %b required 0", err_sof);
    end
  endtask

  task automatic test_eol_err();
    img_width = 12'd8; img_height = 12'd1; tready = 1'b1;
    for (int c = 0; c < 8; c++)
      expect_beat(((c < 4) ? 8'hC0 : 8'hCC) + 8'(c), (c == 0), (c == 7), (c == 7));
    push_word(8'hC0, 4'b0001, 4'b0000);
    push_word(8'hD0, 4'b0000, 4'b1010);
    wait_drain("eol");
    checks++;
    if ({err_sof, err_eol} !== 2'b01) begin
      errors++;
      $display("FAIL eol_err: got sof/eol=%b required 01", {err_sof, err_eol});
    end
    clear_errors();
    checks++;
    if (err_eol !== 1'b0) begin
      errors++;
      $display("FAIL eol_clear: got %b required 0", err_eol);
    end
  endtask

  task automatic test_reset_mid_frame();
    int b0 = beats_seen, n = 0;
    img_width = 12'd8; img_height = 12'd1; tready = 1'b1;
    for (int c = 0; c < 8; c++)
      expect_beat(((c < 4) ? 8'hE0 : 8'hEC) + 8'(c), (c == 0), (c == 7), (c == 7));
    push_word(8'hE0, 4'b0001, 4'b0000);
    push_word(8'hF0, 4'b0000, 4'b1000);
    do begin
      @(posedge clk); #1;
      n++;
    end while (beats_seen - b0 < 5 && n < 30);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    fd_exp = 1'b0;
    for (int c = 0; c < 8; c++)
      expect_beat(((c < 4) ? 8'hF0 : 8'h34) + 8'(c), (c == 0), (c == 7), (c == 7));
    push_word(8'h38, 4'b0000, 4'b1000);
    @(negedge clk);
    checks++;
    if ({tvalid, tuser, tlast, frame_done, err_sof, err_eol, tdata} !== 14'b0) begin
      errors++;
      $display("FAIL midreset_out: got v/u/l/fd/es/ee=%b data=%h required 000000 data=00",
               {tvalid, tuser, tlast, frame_done, err_sof, err_eol}, tdata);
    end
    #1 mon_en = 1'b1;
    wait_drain("midreset");
    checks++;
    if (err_sof !== 1'b1) begin
      errors++;
      $display("FAIL midreset_sof_missing: got err_sof=%b required 1", err_sof);
    end
    clear_errors();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_word();
    test_stall();
    test_sof_resync();
    test_eol_err();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
